// File: rtl/radix4_mult_pkg.sv
// radix4_mult_pkg: shared types and helpers for the radix-4 Booth serial multiplier
//   state_t       : controller states IDLE / BUSY / DONE
//   booth_digit_t : recoded Booth digit {neg, one, two}
//   digit_count() : number of Booth digits per operation
package radix4_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Unsigned operands get an extra digit so the top digit is never negative.
    function automatic int digit_count(input int width, input logic signed_mode);
        return signed_mode ? width / 2 : width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_radix4_digit.sv
// booth_radix4_digit: combinational radix-4 Booth encoder
//   win   : y bits {2i+1, 2i, 2i-1}
//   digit : {neg, one, two} selecting 0, +-x or +-2x
module booth_radix4_digit
    import radix4_mult_pkg::*;
(
    input  logic [2:0]   win,
    output booth_digit_t digit
);

    // 111 is zero, so it must not assert neg.
    assign digit.neg = win[2] & ~(win[1] & win[0]);
    assign digit.one = win[1] ^ win[0];
    assign digit.two = (win == 3'b011) | (win == 3'b100);

endmodule

// File: rtl/radix4_booth_serial_mult.sv
// radix4_booth_serial_mult: radix-4 Booth serial multiplier, one digit per clock
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a multiply (accepted in IDLE or DONE)
//   signed_mode : 1 = two's complement, 0 = unsigned (sampled with start)
//   in_x, in_y  : multiplicand, multiplier
//   out         : full 2*WIDTH-bit product
//   out_scaled  : product >> FRAC_BITS, saturated to WIDTH bits
//   overflow    : out_scaled was clamped
//   busy        : in BUSY
//   finished    : in DONE, outputs valid
module radix4_booth_serial_mult
    import radix4_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [2*WIDTH-1:0] out,
    output logic [WIDTH-1:0]   out_scaled,
    output logic               overflow,
    output logic               busy,
    output logic               finished
);

    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [AW-1:0] UMAX = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    state_t                  state;
    logic                    sm;
    logic                    y_prev;
    logic [WIDTH+1:0]        y_sr;
    logic [CW-1:0]           cnt;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    x_sh;
    logic signed [AW-1:0]    mag;
    logic signed [AW-1:0]    pp;
    logic signed [AW-1:0]    acc_nx;
    logic signed [AW-1:0]    p;
    logic signed [AW-1:0]    hi;
    logic signed [AW-1:0]    lo;
    logic [WIDTH-1:0]        scaled_nx;
    logic                    ovf_nx;
    logic                    last;
    booth_digit_t            d;

    // y is consumed two bits per cycle from the bottom; y_prev holds bit 2i-1.
    booth_radix4_digit u_digit (
        .win   ({y_sr[1:0], y_prev}),
        .digit (d)
    );

    // x_sh already carries the 4^i weight, so each cycle adds digit*x_sh.
    // Arithmetic shift gives floor rounding; unsigned products are never negative.
    always_comb begin
        mag       = d.two ? x_sh <<< 1 : d.one ? x_sh : '0;
        pp        = d.neg ? -mag : mag;
        acc_nx    = acc + pp;
        p         = acc_nx >>> FRAC_BITS;
        hi        = sm ? SMAX : UMAX;
        lo        = sm ? SMIN : '0;
        ovf_nx    = (p > hi) || (p < lo);
        scaled_nx = (p > hi) ? hi[WIDTH-1:0] : (p < lo) ? lo[WIDTH-1:0] : p[WIDTH-1:0];
        last      = cnt == CW'(digit_count(WIDTH, sm) - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sm         <= 1'b0;
            y_prev     <= 1'b0;
            y_sr       <= '0;
            cnt        <= '0;
            acc        <= '0;
            x_sh       <= '0;
            out        <= '0;
            out_scaled <= '0;
            overflow   <= 1'b0;
        end else if (start && state != BUSY) begin
            state  <= BUSY;
            sm     <= signed_mode;
            x_sh   <= {{(AW-WIDTH){signed_mode & in_x[WIDTH-1]}}, in_x};
            y_sr   <= {{2{signed_mode & in_y[WIDTH-1]}}, in_y};
            y_prev <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nx;
            x_sh   <= x_sh <<< 2;
            y_sr   <= y_sr >> 2;
            y_prev <= y_sr[1];
            cnt    <= cnt + CW'(1);
            if (last) begin
                state      <= DONE;
                out        <= acc_nx[2*WIDTH-1:0];
                out_scaled <= scaled_nx;
                overflow   <= ovf_nx;
            end
        end
    end

    assign busy     = state == BUSY;
    assign finished = state == DONE;

endmodule

// File: tb/tb_radix4_booth_serial_mult.sv
// tb_radix4_booth_serial_mult: directed self-checking bench for radix4_booth_serial_mult
module tb_radix4_booth_serial_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [15:0] out;
    logic [7:0]  out_scaled;
    logic        overflow;
    logic        busy;
    logic        finished;

    int pass_cnt = 0;
    int total = 0;
    int lat;

    radix4_booth_serial_mult #(.WIDTH(8), .FRAC_BITS(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .in_x        (in_x),
        .in_y        (in_y),
        .out         (out),
        .out_scaled  (out_scaled),
        .overflow    (overflow),
        .busy        (busy),
        .finished    (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present operands, let the accepting edge pass, then count edges until finished.
    task automatic accept(input logic sm, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        signed_mode = sm;
        in_x = x;
        in_y = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!finished && cycles < 20) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic run_op(input logic sm, input logic [7:0] x, input logic [7:0] y, output int cycles);
        accept(sm, x, y);
        wait_done(cycles);
    endtask

    initial begin
        #12;
        check("reset_out", out, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_finished", {15'd0, finished}, 16'd0);
        check("reset_ovf", {15'd0, overflow}, 16'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: -3 * 7 signed
        accept(1'b1, 8'hFD, 8'h07);
        check("t1_busy", {15'd0, busy}, 16'd1);
        wait_done(lat);
        check("t1_lat", 16'(lat), 16'd4);
        check("t1_out", out, 16'hFFEB);
        check("t1_scaled", {8'd0, out_scaled}, 16'h00FF);
        check("t1_ovf", {15'd0, overflow}, 16'd0);

        // 2: -128 * -128 saturates high
        run_op(1'b1, 8'h80, 8'h80, lat);
        check("t2_out", out, 16'h4000);
        check("t2_scaled", {8'd0, out_scaled}, 16'h007F);
        check("t2_ovf", {15'd0, overflow}, 16'd1);

        // 3: unsigned 255 * 255
        run_op(1'b0, 8'hFF, 8'hFF, lat);
        check("t3_lat", 16'(lat), 16'd5);
        check("t3_out", out, 16'hFE01);
        check("t3_scaled", {8'd0, out_scaled}, 16'h00FF);
        check("t3_ovf", {15'd0, overflow}, 16'd1);

        // 4: Q3.5 1.0 * 1.5
        run_op(1'b1, 8'h20, 8'h30, lat);
        check("t4_out", out, 16'h0600);
        check("t4_scaled", {8'd0, out_scaled}, 16'h0030);
        check("t4_ovf", {15'd0, overflow}, 16'd0);

        // unsigned in range: 128 * 2 = 256, 256 >> 5 = 8
        run_op(1'b0, 8'h80, 8'h02, lat);
        check("u_lat", 16'(lat), 16'd5);
        check("u_out", out, 16'h0100);
        check("u_scaled", {8'd0, out_scaled}, 16'h0008);
        check("u_ovf", {15'd0, overflow}, 16'd0);

        // signed low saturation: 127 * -127 = -16129, floor(/32) = -505
        run_op(1'b1, 8'h7F, 8'h81, lat);
        check("neg_out", out, 16'hC0FF);
        check("neg_scaled", {8'd0, out_scaled}, 16'h0080);
        check("neg_ovf", {15'd0, overflow}, 16'd1);

        // DONE holds with start low
        repeat (3) @(posedge clk);
        #1;
        check("hold_finished", {15'd0, finished}, 16'd1);
        check("hold_out", out, 16'hC0FF);

        // 5: start and operand changes during BUSY are ignored
        accept(1'b1, 8'h05, 8'h06);
        check("t5_finished_drop", {15'd0, finished}, 16'd0);
        @(negedge clk);
        start = 1'b1;
        signed_mode = 1'b0;
        in_x = 8'hAA;
        in_y = 8'h55;
        @(negedge clk) start = 1'b0;
        #1 lat = 0;
        wait_done(lat);
        check("t5_lat", 16'(lat + 1), 16'd4);
        check("t5_out", out, 16'h001E);
        check("t5_scaled", {8'd0, out_scaled}, 16'h0000);

        // back-to-back start in DONE; old result holds while BUSY
        accept(1'b1, 8'h7F, 8'h7F);
        check("b2b_finished_drop", {15'd0, finished}, 16'd0);
        check("b2b_hold_out", out, 16'h001E);
        wait_done(lat);
        check("b2b_lat", 16'(lat), 16'd4);
        check("b2b_out", out, 16'h3F01);
        check("b2b_scaled", {8'd0, out_scaled}, 16'h007F);
        check("b2b_ovf", {15'd0, overflow}, 16'd1);

        // 6: reset two cycles into an operation
        accept(1'b1, 8'h11, 8'h22);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_out", out, 16'h0000);
        check("rst_scaled", {8'd0, out_scaled}, 16'h0000);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_finished", {15'd0, finished}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op(1'b1, 8'h03, 8'h05, lat);
        check("t6_lat", 16'(lat), 16'd4);
        check("t6_out", out, 16'h000F);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
